// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder scan controller.
// Optional build macro used by the top: DECODER_SCAN_DUTY_EN.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // Inactive levels of the decoder enables (G1 active-high, G2A/G2B active-low)
  localparam logic G1_OFF   = 1'b0;
  localparam logic G2_OFF_N = 1'b1;

  // Index of the lowest set bit; returns 0 for an empty mask
  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_next_chan_sel.sv
// Combinational search for the next enabled channel strictly above the
// current one. last_o flags that no higher channel is enabled; next_o then
// simply echoes the current index.
module next_chan_sel (
  input  logic [7:0] mask_i,
  input  logic [2:0] cur_i,
  output logic [2:0] next_o,
  output logic       last_o
);

  // Scan from the top down so the closest higher set bit wins
  always_comb begin
    next_o = cur_i;
    last_o = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (mask_i[i] && (3'(i) > cur_i)) begin
        next_o = 3'(i);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller in front of a 3-to-8 active-low decoder. Walks the set bits
// of a latched channel mask, blanking the decoder around every select change
// so decoded outputs never glitch.
// Optional build macro: DECODER_SCAN_DUTY_EN adds duty_i, which limits how
// many cycles of each dwell the decoder is actually enabled.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | decoder disabled, waiting for start_i
// BLANK | select lines settled on a new channel, decoder still disabled
// DRIVE | decoder enabled on the current channel for the dwell period
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             continuous_i,
  input  logic [7:0]       chan_mask_i,
`ifdef DECODER_SCAN_DUTY_EN
  input  logic [CNT_W-1:0] duty_i,
`endif
  output logic             select_a_o,
  output logic             select_b_o,
  output logic             select_c_o,
  output logic             g1_en_o,
  output logic             g2a_en_n_o,
  output logic             g2b_en_n_o,
  output logic [2:0]       chan_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  // The enables are registered from the next state, so a select update always
  // spends at least one cycle with the decoder off. With BLANK_CYCLES = 0 the
  // blank phase collapses to that single settling cycle.
  localparam int              BLANK_EFF  = (BLANK_CYCLES == 0) ? 1 : BLANK_CYCLES;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       chan_q, chan_d;
  logic [7:0]       mask_q, mask_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;

  logic [2:0]       nxt_chan;
  logic             nxt_last;

`ifdef DECODER_SCAN_DUTY_EN
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W:0]   elapsed_d;
`endif

  next_chan_sel u_next_chan_sel (
    .mask_i (mask_q),
    .cur_i  (chan_q),
    .next_o (nxt_chan),
    .last_o (nxt_last)
  );

  // State, counter, channel and latched-mask registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chan_q  <= 3'd0;
      mask_q  <= 8'd0;
`ifdef DECODER_SCAN_DUTY_EN
      duty_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      mask_q  <= mask_d;
`ifdef DECODER_SCAN_DUTY_EN
      duty_q  <= duty_d;
`endif
    end
  end

  // Next-state logic: blank/dwell down-counter, channel stepping, frame end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    mask_d  = mask_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          if (chan_mask_i != 8'd0) begin
            mask_d  = chan_mask_i;
            chan_d  = lowest_set(chan_mask_i);
            state_d = BLANK;
            cnt_d   = BLANK_LOAD;
          end else begin
            // Empty frame completes immediately
            done_d = 1'b1;
          end
        end
      end

      BLANK: begin
        if (cnt_q == '0) begin
          state_d = DRIVE;
          cnt_d   = DWELL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!nxt_last) begin
          chan_d  = nxt_chan;
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
        end else begin
          done_d = 1'b1;
          if (continuous_i && (chan_mask_i != 8'd0)) begin
            mask_d  = chan_mask_i;
            chan_d  = lowest_set(chan_mask_i);
            state_d = BLANK;
            cnt_d   = BLANK_LOAD;
          end else begin
            // Selects hold on the last channel
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort: drop back to IDLE without a frame-done pulse, selects hold
    if (stop_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      chan_d  = chan_q;
      mask_d  = mask_q;
      done_d  = 1'b0;
    end

`ifdef DECODER_SCAN_DUTY_EN
    // Duty is captured once per channel, on the way into DRIVE
    duty_d = ((state_q != DRIVE) && (state_d == DRIVE)) ? duty_i : duty_q;
`endif
  end

  // Output decode from the next state so every output is a flop
  always_comb begin
`ifdef DECODER_SCAN_DUTY_EN
    // Dwell cycles already spent in the cycle being decoded (0 on entry)
    elapsed_d = {1'b0, DWELL_LOAD} - {1'b0, cnt_d};
    en_d      = (state_d == DRIVE) && (elapsed_d < {1'b0, duty_d});
`else
    en_d      = (state_d == DRIVE);
`endif
    busy_d    = (state_d != IDLE);
  end

  // Registered decoder enable, busy and frame-done outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign select_a_o   = chan_q[0];
  assign select_b_o   = chan_q[1];
  assign select_c_o   = chan_q[2];
  assign chan_o       = chan_q;
  assign g1_en_o      = en_q ? ~G1_OFF   : G1_OFF;
  assign g2a_en_n_o   = en_q ? ~G2_OFF_N : G2_OFF_N;
  assign g2b_en_n_o   = en_q ? ~G2_OFF_N : G2_OFF_N;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule
